// File: rtl/key_pkg.sv
// Shared key-handling definitions: FSM state encoding and default timing,
// so the debouncer and the event decoder draw on one timing source.
package key_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      LONG = 2'd2
   } key_state_e;

   // Defaults in sys_clk cycles.
   localparam int LONG_TIME_DEF   = 24000000;
   localparam int REPEAT_TIME_DEF = 6000000;

endpackage

// File: rtl/key_edge_detect.sv
// Level-to-edge front end: normalizes the key polarity so that 1 means
// pressed, keeps the previous normalized level and reports rise/fall.
// The previous level resets to "released", so a key held through reset
// shows up as a rise on the first edge afterwards.
module key_edge_detect #(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic key_in,
   output logic rise,
   output logic fall
);

   logic norm_s;
   logic prev_r;

   assign norm_s = key_in ^ ACTIVE_LOW;

   // Previous normalized level, released after reset.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         prev_r <= 1'b0;
      end else begin
         prev_r <= norm_s;
      end
   end

   assign rise = norm_s & ~prev_r;
   assign fall = ~norm_s & prev_r;

endmodule

// File: rtl/key_event_decoder.sv
// Turns a debounced key level into single-cycle press, release, long-press
// and auto-repeat events, plus held/long-hold flags and a wrapping press
// counter. All outputs are registered.
module key_event_decoder
   import key_pkg::*;
#(
   parameter bit ACTIVE_LOW  = 1'b1,
   parameter int LONG_TIME   = LONG_TIME_DEF,
   parameter int REPEAT_TIME = REPEAT_TIME_DEF,
   parameter bit REPEAT_EN   = 1'b1,
   parameter int BITS        = 25
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       key_in,
   output logic       press_pulse,
   output logic       release_pulse,
   output logic       long_pulse,
   output logic       repeat_pulse,
   output logic       key_held,
   output logic       long_active,
   output logic [7:0] press_cnt
);

   localparam logic [BITS-1:0] LONG_LAST = BITS'(LONG_TIME - 1);
   localparam logic [BITS-1:0] REP_LAST  = BITS'(REPEAT_TIME - 1);
   localparam logic [BITS-1:0] CNT_ONE   = BITS'(1);

   logic            rise_s;
   logic            fall_s;
   key_state_e      state_r;
   key_state_e      state_nxt_s;
   logic [BITS-1:0] cnt_r;
   logic [BITS-1:0] cnt_nxt_s;
   logic [7:0]      press_cnt_r;
   logic [7:0]      press_cnt_nxt_s;
   logic            press_nxt_s;
   logic            release_nxt_s;
   logic            long_nxt_s;
   logic            repeat_nxt_s;
   logic            press_r;
   logic            release_r;
   logic            long_r;
   logic            repeat_r;
   logic            key_held_r;
   logic            long_active_r;

   key_edge_detect #(
      .ACTIVE_LOW (ACTIVE_LOW)
   ) u_edge (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .key_in    (key_in),
      .rise      (rise_s),
      .fall      (fall_s)
   );

   // State, hold counter, press counter and all registered outputs.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_r       <= IDLE;
         cnt_r         <= '0;
         press_cnt_r   <= 8'd0;
         press_r       <= 1'b0;
         release_r     <= 1'b0;
         long_r        <= 1'b0;
         repeat_r      <= 1'b0;
         key_held_r    <= 1'b0;
         long_active_r <= 1'b0;
      end else begin
         state_r       <= state_nxt_s;
         cnt_r         <= cnt_nxt_s;
         press_cnt_r   <= press_cnt_nxt_s;
         press_r       <= press_nxt_s;
         release_r     <= release_nxt_s;
         long_r        <= long_nxt_s;
         repeat_r      <= repeat_nxt_s;
         key_held_r    <= (state_nxt_s != IDLE);
         long_active_r <= (state_nxt_s == LONG);
      end
   end

   // Next-state decision; release always wins over a same-cycle timeout.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (rise_s) state_nxt_s = HOLD;
            else        state_nxt_s = IDLE;
         end
         HOLD: begin
            if (fall_s)                  state_nxt_s = IDLE;
            else if (cnt_r == LONG_LAST) state_nxt_s = LONG;
            else                         state_nxt_s = HOLD;
         end
         LONG: begin
            if (fall_s) state_nxt_s = IDLE;
            else        state_nxt_s = LONG;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Pulse generation and counter updates for the coming edge.
   always_comb begin
      press_nxt_s     = 1'b0;
      release_nxt_s   = 1'b0;
      long_nxt_s      = 1'b0;
      repeat_nxt_s    = 1'b0;
      cnt_nxt_s       = cnt_r;
      press_cnt_nxt_s = press_cnt_r;
      case (state_r)
         IDLE: begin
            if (rise_s) begin
               press_nxt_s     = 1'b1;
               press_cnt_nxt_s = press_cnt_r + 8'd1;
               cnt_nxt_s       = '0;
            end else begin
               cnt_nxt_s = cnt_r;
            end
         end
         HOLD: begin
            if (fall_s) begin
               release_nxt_s = 1'b1;
            end else if (cnt_r == LONG_LAST) begin
               long_nxt_s = 1'b1;
               cnt_nxt_s  = '0;
            end else begin
               cnt_nxt_s = cnt_r + CNT_ONE;
            end
         end
         LONG: begin
            if (fall_s) begin
               release_nxt_s = 1'b1;
            end else if (REPEAT_EN && (cnt_r == REP_LAST)) begin
               repeat_nxt_s = 1'b1;
               cnt_nxt_s    = '0;
            end else if (cnt_r != REP_LAST) begin
               cnt_nxt_s = cnt_r + CNT_ONE;
            end else begin
               // Repeat disabled: park at the last count.
               cnt_nxt_s = cnt_r;
            end
         end
         default: begin
            cnt_nxt_s = '0;
         end
      endcase
   end

   assign press_pulse   = press_r;
   assign release_pulse = release_r;
   assign long_pulse    = long_r;
   assign repeat_pulse  = repeat_r;
   assign key_held      = key_held_r;
   assign long_active   = long_active_r;
   assign press_cnt     = press_cnt_r;

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder with LONG_TIME=10, REPEAT_TIME=4.
// dut_a: active-low, repeat on; dut_b: active-low, repeat off;
// dut_c: active-high fed with the inverted key, so it must match dut_a.
module tb_key_event_decoder;

   localparam int LT = 10;
   localparam int RT = 4;

   logic sys_clk   = 1'b0;
   logic sys_rst_n = 1'b0;
   logic key_a     = 1'b1;
   logic key_c;

   logic pp_a, rp_a, lp_a, rpt_a, kh_a, la_a;
   logic pp_b, rp_b, lp_b, rpt_b, kh_b, la_b;
   logic pp_c, rp_c, lp_c, rpt_c, kh_c, la_c;
   logic [7:0] pc_a, pc_b, pc_c;

   int n_checks = 0;
   int n_pass   = 0;
   int n_long_a = 0, n_rep_a = 0, n_long_b = 0, n_rep_b = 0;

   // behavioural model: previous pressed flag, hold age since press, presses
   bit m_prev;
   int m_age;
   int m_cnt;

   assign key_c = ~key_a;

   always #5 sys_clk = ~sys_clk;

   key_event_decoder #(.ACTIVE_LOW(1'b1), .LONG_TIME(LT), .REPEAT_TIME(RT),
                       .REPEAT_EN(1'b1), .BITS(8)) dut_a (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_in(key_a),
      .press_pulse(pp_a), .release_pulse(rp_a), .long_pulse(lp_a),
      .repeat_pulse(rpt_a), .key_held(kh_a), .long_active(la_a), .press_cnt(pc_a));

   key_event_decoder #(.ACTIVE_LOW(1'b1), .LONG_TIME(LT), .REPEAT_TIME(RT),
                       .REPEAT_EN(1'b0), .BITS(8)) dut_b (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_in(key_a),
      .press_pulse(pp_b), .release_pulse(rp_b), .long_pulse(lp_b),
      .repeat_pulse(rpt_b), .key_held(kh_b), .long_active(la_b), .press_cnt(pc_b));

   key_event_decoder #(.ACTIVE_LOW(1'b0), .LONG_TIME(LT), .REPEAT_TIME(RT),
                       .REPEAT_EN(1'b1), .BITS(8)) dut_c (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_in(key_c),
      .press_pulse(pp_c), .release_pulse(rp_c), .long_pulse(lp_c),
      .repeat_pulse(rpt_c), .key_held(kh_c), .long_active(la_c), .press_cnt(pc_c));

   function automatic logic [13:0] pack_a();
      return {pp_a, rp_a, lp_a, rpt_a, kh_a, la_a, pc_a};
   endfunction
   function automatic logic [13:0] pack_b();
      return {pp_b, rp_b, lp_b, rpt_b, kh_b, la_b, pc_b};
   endfunction
   function automatic logic [13:0] pack_c();
      return {pp_c, rp_c, lp_c, rpt_c, kh_c, la_c, pc_c};
   endfunction

   task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
      n_checks++;
      if (act !== exp) begin
         $display("FAIL %s at %0t: got %h expected %h (press,rel,long,rep,held,longact,cnt)",
                  name, $time, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic model_reset();
      m_prev = 1'b0;
      m_age  = 0;
      m_cnt  = 0;
   endtask

   // Expected outputs after one clock edge, from the press age of the key.
   task automatic model_edge(output logic [13:0] e_rep, output logic [13:0] e_norep);
      bit pr, p, r, l, rp, la;
      int age_n;
      pr    = (key_a == 1'b0);
      p     = pr && !m_prev;
      r     = !pr && m_prev;
      age_n = p ? 0 : (pr ? m_age + 1 : 0);
      l     = pr && m_prev && (age_n == LT);
      rp    = pr && m_prev && (age_n > LT) && (((age_n - LT) % RT) == 0);
      la    = pr && (age_n >= LT);
      if (p) m_cnt = (m_cnt + 1) % 256;
      e_rep   = {p, r, l, rp,   pr, la, 8'(m_cnt)};
      e_norep = {p, r, l, 1'b0, pr, la, 8'(m_cnt)};
      m_prev  = pr;
      m_age   = age_n;
   endtask

   // One clock edge, all three DUTs compared with the model.
   task automatic cycle();
      logic [13:0] e1, e0;
      @(posedge sys_clk);
      #1;
      model_edge(e1, e0);
      check("dut_a", pack_a(), e1);
      check("dut_b", pack_b(), e0);
      check("dut_c", pack_c(), e1);
      check("excl_a", 14'($countones({pp_a, rp_a, lp_a, rpt_a}) <= 1), 14'd1);
      n_long_a += int'(lp_a);
      n_rep_a  += int'(rpt_a);
      n_long_b += int'(lp_b);
      n_rep_b  += int'(rpt_b);
   endtask

   // Asynchronous reset from wherever we are, released on a falling edge.
   task automatic apply_reset();
      sys_rst_n = 1'b0;
      model_reset();
      #1;
      check("rst_a", pack_a(), 14'd0);
      check("rst_b", pack_b(), 14'd0);
      check("rst_c", pack_c(), 14'd0);
      repeat (2) @(negedge sys_clk);
      sys_rst_n = 1'b1;
   endtask

   typedef struct {
      logic        key;
      logic [13:0] exp;
   } vec_t;

   vec_t tbl[9];

   initial begin
      logic [13:0] d1, d0;

      tbl[0] = '{1'b1, {6'b000000, 8'd0}};
      tbl[1] = '{1'b1, {6'b000000, 8'd0}};
      tbl[2] = '{1'b0, {6'b100010, 8'd1}};
      tbl[3] = '{1'b0, {6'b000010, 8'd1}};
      tbl[4] = '{1'b0, {6'b000010, 8'd1}};
      tbl[5] = '{1'b0, {6'b000010, 8'd1}};
      tbl[6] = '{1'b0, {6'b000010, 8'd1}};
      tbl[7] = '{1'b1, {6'b010000, 8'd1}};
      tbl[8] = '{1'b1, {6'b000000, 8'd1}};

      key_a = 1'b1;
      apply_reset();

      // short press from the table
      for (int i = 0; i < 9; i++) begin
         key_a = tbl[i].key;
         @(posedge sys_clk);
         #1;
         model_edge(d1, d0);
         check("tbl_a", pack_a(), tbl[i].exp);
         check("tbl_b", pack_b(), tbl[i].exp);
         check("tbl_c", pack_c(), tbl[i].exp);
      end

      // long press with repeat
      n_long_a = 0; n_rep_a = 0;
      key_a = 1'b0;
      repeat (25) cycle();
      key_a = 1'b1;
      repeat (2) cycle();
      check("long_cnt_a", 14'(n_long_a), 14'd1);
      check("rep_cnt_a", 14'(n_rep_a), 14'd3);

      // release on the same edge as the long timeout
      n_long_a = 0;
      key_a = 1'b0;
      repeat (10) cycle();
      key_a = 1'b1;
      cycle();
      check("collide_rel", 14'(rp_a), 14'd1);
      check("collide_long", 14'(n_long_a), 14'd0);
      check("collide_held", 14'(kh_a), 14'd0);
      cycle();

      // repeat disabled: one long pulse, no repeats
      n_long_b = 0; n_rep_b = 0;
      key_a = 1'b0;
      repeat (30) cycle();
      check("norep_la_b", 14'(la_b), 14'd1);
      key_a = 1'b1;
      repeat (2) cycle();
      check("norep_long_b", 14'(n_long_b), 14'd1);
      check("norep_rep_b", 14'(n_rep_b), 14'd0);

      // reset mid-LONG with the key still held, press again after reset
      key_a = 1'b0;
      repeat (15) cycle();
      apply_reset();
      cycle();
      check("held_rst_press", 14'(pp_a), 14'd1);
      key_a = 1'b1;
      repeat (2) cycle();

      // randomized run lengths
      for (int i = 0; i < 60; i++) begin
         key_a = ~key_a;
         repeat ($urandom_range(1, 20)) cycle();
      end

      // press counter wrap
      key_a = 1'b1;
      cycle();
      apply_reset();
      for (int i = 0; i < 256; i++) begin
         key_a = 1'b0;
         repeat ($urandom_range(1, 2)) cycle();
         key_a = 1'b1;
         cycle();
      end
      check("wrap_a", 14'(pc_a), 14'd0);
      check("wrap_c", 14'(pc_c), 14'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/key_event_decoder.md
Name: key_event_decoder

Overview:
- Consumes the clean, debounced key level produced by the front-end debouncer and turns it into discrete, single-cycle user events: press, release, long-press and auto-repeat.
- Sits between the debouncer output and the control FSMs, so downstream logic never has to time key levels itself.
- Also provides a held flag, a long-hold flag and a wrapping press counter for menu and step logic.

Parameters:
- ACTIVE_LOW, 1, 1 = key_in low means pressed; 0 = key_in high means pressed.
- LONG_TIME, 24000000, sys_clk cycles of continuous hold, counted from the press edge, before long_pulse fires.
- REPEAT_TIME, 6000000, sys_clk cycles between successive repeat_pulse events once long-press is reached.
- REPEAT_EN, 1, 1 = emit repeat_pulse while in long hold; 0 = no repeat pulses.
- BITS, 25, hold-counter width; must satisfy 2^BITS > max(LONG_TIME, REPEAT_TIME).

Ports:
- sys_clk  input  1  system clock; all logic on the rising edge.
- sys_rst_n  input  1  asynchronous active-low reset.
- key_in  input  1  debounced key level, already synchronous to sys_clk.
- press_pulse  output  1  one-cycle pulse on the press edge.
- release_pulse  output  1  one-cycle pulse on the release edge.
- long_pulse  output  1  one-cycle pulse when hold reaches LONG_TIME.
- repeat_pulse  output  1  one-cycle pulse every REPEAT_TIME while in long hold.
- key_held  output  1  high while state is not IDLE.
- long_active  output  1  high while state is LONG.
- press_cnt  output  8  count of press events; wraps.

Behaviour:
- Interface: one clock (sys_clk); reset sys_rst_n is asynchronous and active-low.
- Reset:
  - All outputs are 0 and press_cnt = 0.
  - State is IDLE, hold counter cnt = 0, and prev (the registered normalized level) = 0, i.e. released.
- Normalization: norm = key_in XOR ACTIVE_LOW, so norm = 1 means pressed. prev <= norm every cycle.
- Edge detection: rise = norm & ~prev; fall = ~norm & prev.
- Latency: all outputs are registered. If key_in changes before edge N, the corresponding pulse is high from edge N to edge N+1. Each pulse is high for exactly one cycle.
- IDLE:
  - rise: press_pulse <= 1, press_cnt <= press_cnt + 1 (255 wraps to 0), cnt <= 0, go to HOLD.
  - fall in IDLE is ignored.
- HOLD:
  - fall: release_pulse <= 1, go to IDLE.
  - else if cnt == LONG_TIME-1: long_pulse <= 1, cnt <= 0, go to LONG.
  - else cnt <= cnt + 1.
  - long_pulse therefore fires LONG_TIME cycles after press_pulse.
- LONG:
  - fall: release_pulse <= 1, go to IDLE.
  - else if REPEAT_EN and cnt == REPEAT_TIME-1: repeat_pulse <= 1, cnt <= 0.
  - else cnt <= cnt + 1; when REPEAT_EN = 0, cnt saturates at REPEAT_TIME-1.
- Simultaneous events: release has priority over the long or repeat timeout on the same cycle. No long_pulse or repeat_pulse is ever issued on a release cycle.
- Status flags: key_held = (state != IDLE) and long_active = (state == LONG), both registered together with the state.
- Key held through reset: because prev resets to released, press_pulse fires on the first edge after sys_rst_n deasserts.
- Reset asserted mid-hold: immediate return to the reset values. No release_pulse is emitted.
- Pulse exclusivity: at most one of the four pulses is high in any cycle.

Decomposition:
- Shared package key_pkg:
  - State encoding constants: IDLE = 2'd0, HOLD = 2'd1, LONG = 2'd2.
  - Default timing constants LONG_TIME_DEF and REPEAT_TIME_DEF, so the debouncer and this block share one timing source.
- One natural sub-module, key_edge_detect: normalization plus the prev register, producing rise and fall. It is reusable by other level-to-event blocks.
- The FSM and counter stay in the top module.

Test Plan (LONG_TIME = 10, REPEAT_TIME = 4, ACTIVE_LOW = 1):
- Short press: key_in low for 5 cycles, then high -> press_pulse 1 cycle after the falling edge of key_in; release_pulse 1 cycle after the rising edge; no long_pulse; press_cnt = 1.
- Long press with repeat: key_in low for 25 cycles -> long_pulse 10 cycles after press_pulse; repeat_pulse at +4, +8 and +12 after long_pulse; long_active high from the long_pulse cycle until release.
- Release collision: release timed so fall coincides with cnt == 9 in HOLD -> release_pulse only, no long_pulse, state IDLE.
- REPEAT_EN = 0: hold for 30 cycles -> exactly one long_pulse, zero repeat_pulse, long_active stays 1 until release.
- Reset cases:
  - key_in held low across reset deassertion -> press_pulse on the first edge after reset.
  - Assert sys_rst_n mid-LONG -> all outputs 0 immediately, no release_pulse.
- press_cnt wrap: 256 short presses -> press_cnt returns to 0; ACTIVE_LOW = 0 run mirrors the first case with inverted key_in.
